// File: rtl/expr_vector_sequencer_if.sv
// Handshake bundle between a vector source/verdict consumer and expr_vector_sequencer.
// The sequencer uses the slave view; the vector source and verdict sink use the master view.
interface expr_vector_sequencer_if #(
    parameter int OPS_W = 60,
    parameter int Y_W   = 90
);
    logic             in_valid;
    logic             in_ready;
    logic [OPS_W-1:0] in_ops;
    logic [Y_W-1:0]   in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [Y_W-1:0]   out_y;
    logic [Y_W-1:0]   out_diff;
    logic             out_fail;

    modport slave (
        input  in_valid,
        input  in_ops,
        input  in_exp,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_y,
        output out_diff,
        output out_fail
    );

    modport master (
        output in_valid,
        output in_ops,
        output in_exp,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_y,
        input  out_diff,
        input  out_fail
    );
endinterface

// File: rtl/expr_vector_sequencer.sv
// Applies one operand vector at a time to a combinational expression block, samples its
// result after SETTLE cycles, and reports a per-vector pass/fail verdict with saturating counts.
module expr_vector_sequencer #(
    parameter int OPS_W  = 60,
    parameter int Y_W    = 90,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    expr_vector_sequencer_if.slave bus,
    output logic [OPS_W-1:0]     dut_ops_o,
    input  logic [Y_W-1:0]       dut_y_i,
    input  logic                 clr_cnt_i,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    state_t           state_q,      state_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [OPS_W-1:0] ops_q,        ops_d;
    logic [Y_W-1:0]   exp_q,        exp_d;
    logic             out_valid_q,  out_valid_d;
    logic [Y_W-1:0]   out_y_q,      out_y_d;
    logic [Y_W-1:0]   out_diff_q,   out_diff_d;
    logic             out_fail_q,   out_fail_d;
    logic [CNT_W-1:0] pass_cnt_q,   pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q,   fail_cnt_d;
    logic [Y_W-1:0]   diff_s;

    assign diff_s = dut_y_i ^ exp_q;

    // Next-state, capture and counter logic; every register holds unless its state acts on it.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        ops_d        = ops_q;
        exp_d        = exp_q;
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_diff_d   = out_diff_q;
        out_fail_d   = out_fail_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    ops_d        = bus.in_ops;
                    exp_d        = bus.in_exp;
                    settle_cnt_d = SETTLE_INIT;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    out_y_d     = dut_y_i;
                    out_diff_d  = diff_s;
                    out_fail_d  = |diff_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_REPORT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (out_fail_q) begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end else begin
                        pass_cnt_d = sat_inc(pass_cnt_q);
                    end
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // A clear wins over a retire landing in the same cycle.
        if (clr_cnt_i) begin
            pass_cnt_d = {CNT_W{1'b0}};
            fail_cnt_d = {CNT_W{1'b0}};
        end else begin
            pass_cnt_d = pass_cnt_d;
            fail_cnt_d = fail_cnt_d;
        end
    end

    // State and datapath registers with synchronous reset that discards any vector in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= 4'd0;
            ops_q        <= {OPS_W{1'b0}};
            exp_q        <= {Y_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_y_q      <= {Y_W{1'b0}};
            out_diff_q   <= {Y_W{1'b0}};
            out_fail_q   <= 1'b0;
            pass_cnt_q   <= {CNT_W{1'b0}};
            fail_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            ops_q        <= ops_d;
            exp_q        <= exp_d;
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_diff_q   <= out_diff_d;
            out_fail_q   <= out_fail_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_diff  = out_diff_q;
    assign bus.out_fail  = out_fail_q;
    assign dut_ops_o     = ops_q;
    assign pass_cnt_o    = pass_cnt_q;
    assign fail_cnt_o    = fail_cnt_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Scoreboard bench for expr_vector_sequencer: a model expression block that shows garbage
// until its operands have been stable for one edge, directed vectors, and a verdict monitor.
module tb_expr_vector_sequencer;
    localparam int OPS_W  = 60;
    localparam int Y_W    = 90;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 4;  // narrow counters so saturation is reachable in few vectors

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [Y_W-1:0] diff;
        logic           fail;
    } verdict_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [OPS_W-1:0] dut_ops;
    logic [Y_W-1:0]   dut_y;
    logic [OPS_W-1:0] last_ops;
    logic             clr_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;
    verdict_t sb[$];

    expr_vector_sequencer_if #(.OPS_W(OPS_W), .Y_W(Y_W)) bus ();

    expr_vector_sequencer #(
        .OPS_W(OPS_W), .Y_W(Y_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dut_ops_o (dut_ops),
        .dut_y_i   (dut_y),
        .clr_cnt_i (clr_cnt),
        .pass_cnt_o(pass_cnt),
        .fail_cnt_o(fail_cnt),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [Y_W-1:0] y_model(input logic [OPS_W-1:0] ops);
        logic [59:0] hi;
        logic [59:0] lo;
        logic [59:0] prod;
        hi   = {30'd0, ops[59:30]};
        lo   = {30'd0, ops[29:0]};
        prod = hi * lo;
        return {prod, ops[59:30] ^ ops[29:0]};
    endfunction

    // Expression block stand-in: inverted result until operands have survived one edge.
    always @(posedge clk) last_ops <= dut_ops;
    assign dut_y = (dut_ops == last_ops) ? y_model(dut_ops) : ~y_model(dut_ops);

    task automatic check(input string name, input logic [Y_W-1:0] act, input logic [Y_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Verdict monitor: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        verdict_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_verdict: got out_y %0h expected no verdict", bus.out_y);
            end else begin
                e = sb.pop_front();
                check("out_y",    bus.out_y,    e.y);
                check("out_diff", bus.out_diff, e.diff);
                check("out_fail", {89'd0, bus.out_fail}, {89'd0, e.fail});
            end
        end
    end

    task automatic send(input logic [OPS_W-1:0] ops, input logic [Y_W-1:0] mask);
        int n;
        verdict_t e;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 90'd0, 90'd1);
        bus.in_valid = 1'b1;
        bus.in_ops   = ops;
        bus.in_exp   = y_model(ops) ^ mask;
        e.y    = y_model(ops);
        e.diff = mask;
        e.fail = |mask;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_ops   = ~ops;
        bus.in_exp   = ~bus.in_exp;
        check("dut_ops_after_accept", {30'd0, dut_ops}, {30'd0, ops});
    endtask

    // Called one delta past the accept edge; returns with out_valid observed (or timed out).
    task automatic wait_verdict();
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("verdict_latency", 90'(lat), 90'(SETTLE));
    endtask

    task automatic run_vec(input logic [OPS_W-1:0] ops, input logic [Y_W-1:0] mask);
        send(ops, mask);
        wait_verdict();
        @(posedge clk); #1;
        check("out_valid_after_retire", {89'd0, bus.out_valid}, 90'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [Y_W-1:0] bit89;
        logic [Y_W-1:0] y_hold;
        bit89 = 90'd1 << 89;
        rst = 1'b1;
        clr_cnt = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ops = 60'd0;
        bus.in_exp = 90'd0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {89'd0, bus.in_ready},  90'd1);
        check("rst_out_valid", {89'd0, bus.out_valid}, 90'd0);
        check("rst_dut_ops",   {30'd0, dut_ops},       90'd0);
        check("rst_pass_cnt",  90'(pass_cnt),          90'd0);
        check("rst_fail_cnt",  90'(fail_cnt),          90'd0);
        check("rst_busy",      {89'd0, busy},          90'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Passing vector
        run_vec(60'h0123456789ABCDE, 90'd0);
        check("pass_cnt_1", 90'(pass_cnt), 90'd1);
        check("fail_cnt_0", 90'(fail_cnt), 90'd0);

        // Top-bit mismatch
        run_vec(60'h0FEDCBA98765432, bit89);
        check("fail_cnt_1", 90'(fail_cnt), 90'd1);
        check("pass_cnt_still_1", 90'(pass_cnt), 90'd1);

        // Back-pressure in REPORT
        bus.out_ready = 1'b0;
        send(60'hABCDEF012345678, 90'h5A5);
        wait_verdict();
        y_hold = y_model(60'hABCDEF012345678);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", {89'd0, bus.out_valid}, 90'd1);
            check("stall_out_y",     bus.out_y,              y_hold);
            check("stall_out_diff",  bus.out_diff,           90'h5A5);
            check("stall_in_ready",  {89'd0, bus.in_ready},  90'd0);
            check("stall_fail_cnt",  90'(fail_cnt),          90'd1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_fail_cnt", 90'(fail_cnt), 90'd2);
        repeat (3) @(posedge clk);
        #1;
        check("release_once_fail_cnt", 90'(fail_cnt), 90'd2);
        check("release_once_pass_cnt", 90'(pass_cnt), 90'd1);

        // Saturation: clear, climb to max-1, then three more passes
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("clr_pass_cnt", 90'(pass_cnt), 90'd0);
        check("clr_fail_cnt", 90'(fail_cnt), 90'd0);
        for (int i = 0; i < 14; i++) run_vec(60'h000000100000001 * 60'(i + 3), 90'd0);
        check("pass_cnt_max_minus_1", 90'(pass_cnt), 90'd14);
        for (int i = 0; i < 3; i++) begin
            run_vec(60'h123456789000000 + 60'(i), 90'd0);
            check("pass_cnt_saturated", 90'(pass_cnt), 90'd15);
        end

        // Clear coinciding with a failing retire
        send(60'h00000000000FFFF, 90'd3);
        wait_verdict();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("clr_retire_pass_cnt", 90'(pass_cnt), 90'd0);
        check("clr_retire_fail_cnt", 90'(fail_cnt), 90'd0);

        // Reset in SETTLE aborts the vector
        send(60'h111111111111111, 90'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        repeat (4) begin
            check("abort_settle_out_valid", {89'd0, bus.out_valid}, 90'd0);
            @(posedge clk); #1;
        end
        check("abort_settle_pass_cnt", 90'(pass_cnt), 90'd0);
        check("abort_settle_busy",     {89'd0, busy},  90'd0);

        // Reset in REPORT aborts the verdict
        bus.out_ready = 1'b0;
        send(60'h222222222222222, 90'd0);
        wait_verdict();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        void'(sb.pop_back());
        check("abort_report_out_valid", {89'd0, bus.out_valid}, 90'd0);
        check("abort_report_in_ready",  {89'd0, bus.in_ready},  90'd1);
        check("abort_report_pass_cnt",  90'(pass_cnt),          90'd0);
        check("abort_report_fail_cnt",  90'(fail_cnt),          90'd0);

        // Normal operation afterwards
        run_vec(60'h333333333333333, 90'd0);
        check("post_abort_pass_cnt", 90'(pass_cnt), 90'd1);
        check("scoreboard_drained", 90'(sb.size()), 90'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
